// File: rtl/uart_cmd_decoder_if.sv
// Byte-level handshake between the uart rx/tx pair and the command decoder.
interface uart_cmd_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_send;
    logic [7:0] tx_data;

    modport master (output rx_valid, rx_data, tx_busy, input tx_send, tx_data);
    modport slave  (input rx_valid, rx_data, tx_busy, output tx_send, tx_data);
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses ASCII LED commands from the uart rx stream into an LED register and
// queues ASCII acknowledgements back to the uart transmitter.
//   state     | meaning
//   IDLE      | waiting for a command letter
//   ARG1      | expecting toggle digit or first hex digit
//   ARG2      | expecting second hex digit of a write
//   WAIT_CR   | command complete, waiting for CR to execute
//   DISCARD   | bad input seen, swallowing bytes until CR
module uart_cmd_decoder #(
    parameter int LED_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int RESP_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_decoder_if.slave    uart,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 cmd_err
);
    localparam int AW = $clog2(RESP_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] CH_LF = 8'h0A, CH_CR = 8'h0D, CH_K = 8'h4B, CH_E = 8'h45;
    localparam logic [7:0] CH_T = 8'h54, CH_W = 8'h57, CH_R = 8'h52;
    localparam logic [7:0] TOG_LIM = 8'h30 + 8'(LED_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_ARG1, S_ARG2, S_WAIT_CR, S_DISCARD} state_t;
    typedef enum logic [1:0] {C_TOG, C_WR, C_RD} cmd_t;

    state_t          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic [3:0]      arg_hi_q, arg_hi_d, arg_lo_q, arg_lo_d;
    logic [TW-1:0]   tmo_cnt_q;
    logic            tmo_hit, exec, err_req;
    logic [4:0]      hx;
    logic            tog_ok;

    logic [7:0]      mem [RESP_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, free;
    logic [1:0]      push_n, hold_q;
    logic [7:0]      push_b [3];
    logic            pop;
    logic [LED_WIDTH-1:0] led_d;
    logic [7:0]      led_ext;
    logic            err_d;

    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      return {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        else                               return 5'b0;
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign hx      = hex_dec(uart.rx_data);
    assign tog_ok  = (uart.rx_data >= 8'h30) && (uart.rx_data < TOG_LIM);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit = (state_q != S_IDLE) && !uart.rx_valid &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        arg_hi_d = arg_hi_q;
        arg_lo_d = arg_lo_q;
        exec     = 1'b0;
        err_req  = 1'b0;
        if (uart.rx_valid && uart.rx_data != CH_LF) begin
            case (state_q)
                S_IDLE: begin
                    if (uart.rx_data == CH_CR) state_d = S_IDLE;
                    else if (uart.rx_data == CH_T) begin cmd_d = C_TOG; state_d = S_ARG1; end
                    else if (uart.rx_data == CH_W) begin cmd_d = C_WR;  state_d = S_ARG1; end
                    else if (uart.rx_data == CH_R) begin cmd_d = C_RD;  state_d = S_WAIT_CR; end
                    else state_d = S_DISCARD;
                end
                S_ARG1: begin
                    if (uart.rx_data == CH_CR) begin
                        err_req = 1'b1;
                        state_d = S_IDLE;
                    end else if (cmd_q == C_TOG) begin
                        if (tog_ok) begin arg_lo_d = hx[3:0]; state_d = S_WAIT_CR; end
                        else state_d = S_DISCARD;
                    end else begin
                        if (hx[4]) begin arg_hi_d = hx[3:0]; state_d = S_ARG2; end
                        else state_d = S_DISCARD;
                    end
                end
                S_ARG2: begin
                    if (uart.rx_data == CH_CR) begin
                        err_req = 1'b1;
                        state_d = S_IDLE;
                    end else if (hx[4]) begin
                        arg_lo_d = hx[3:0];
                        state_d  = S_WAIT_CR;
                    end else state_d = S_DISCARD;
                end
                S_WAIT_CR: begin
                    if (uart.rx_data == CH_CR) begin exec = 1'b1; state_d = S_IDLE; end
                    else state_d = S_DISCARD;
                end
                S_DISCARD: begin
                    if (uart.rx_data == CH_CR) begin err_req = 1'b1; state_d = S_IDLE; end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            err_req = 1'b1;
            state_d = S_IDLE;
        end
    end

    // Space check uses the pre-pop count so a command never depends on tx timing.
    assign free    = CW'(RESP_DEPTH) - count_q;
    assign led_ext = 8'(led_out);

    always_comb begin
        led_d  = led_out;
        push_n = 2'd0;
        err_d  = 1'b0;
        for (int i = 0; i < 3; i++) push_b[i] = 8'h00;
        if (exec) begin
            if (cmd_q == C_RD) begin
                if (free >= CW'(3)) begin
                    push_n    = 2'd3;
                    push_b[0] = hex_chr(led_ext[7:4]);
                    push_b[1] = hex_chr(led_ext[3:0]);
                    push_b[2] = CH_K;
                end else err_d = 1'b1;
            end else if (free >= CW'(1)) begin
                push_n    = 2'd1;
                push_b[0] = CH_K;
                if (cmd_q == C_TOG) begin
                    for (int i = 0; i < LED_WIDTH; i++)
                        if (arg_lo_q == 4'(i)) led_d[i] = ~led_out[i];
                end else led_d = LED_WIDTH'({arg_hi_q, arg_lo_q});
            end else err_d = 1'b1;
        end else if (err_req) begin
            err_d = 1'b1;
            if (free >= CW'(1)) begin
                push_n    = 2'd1;
                push_b[0] = CH_E;
            end
        end
    end

    assign pop = (count_q != '0) && !uart.tx_busy && (hold_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= C_TOG;
            arg_hi_q  <= 4'h0;
            arg_lo_q  <= 4'h0;
            tmo_cnt_q <= '0;
            led_out   <= '0;
            cmd_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            arg_hi_q <= arg_hi_d;
            arg_lo_q <= arg_lo_d;
            led_out  <= led_d;
            cmd_err  <= err_d;
            if (state_q == S_IDLE || uart.rx_valid || tmo_hit) tmo_cnt_q <= '0;
            else tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (2'(i) < push_n) mem[wr_ptr_q + AW'(i)] <= push_b[i];
    end

    // hold_q counts the send cycle plus two holdoff cycles where tx_busy is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= 2'd0;
            uart.tx_send <= 1'b0;
            uart.tx_data <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_n);
            count_q  <= count_q + CW'(push_n) - CW'(pop);
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + 1'b1;
                uart.tx_send <= 1'b1;
                uart.tx_data <= mem[rd_ptr_q];
                hold_q       <= 2'd3;
            end else begin
                uart.tx_send <= 1'b0;
                if (hold_q != 2'd0) hold_q <= hold_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: command strings in, LED register and
// transmitted acknowledgement bytes checked against hand-computed values.
module tb_uart_cmd_decoder;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] led_out;
    logic       cmd_err;
    uart_cmd_decoder_if u_if ();

    uart_cmd_decoder #(.LED_WIDTH(4), .TIMEOUT_CYCLES(TMO), .RESP_DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart    (u_if.slave),
        .led_out (led_out),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         err_cnt = 0;
    int         viol = 0;
    int         busy_cnt = 0;
    bit         hold_busy = 0;
    logic [7:0] tx_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // exp holds n bytes, first transmitted byte in the most significant position
    task automatic chk_tx(input string tag, input int n, input logic [31:0] exp);
        chk({tag, "_cnt"}, 32'(tx_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i),
                (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF,
                {24'h0, exp[8*(n-1-i) +: 8]});
        tx_q.delete();
    endtask

    task automatic send(input string s, input bit cr);
        for (int i = 0; i < s.len(); i++) begin
            u_if.rx_valid = 1'b1;
            u_if.rx_data  = s[i];
            @(posedge clk); #1;
        end
        if (cr) begin
            u_if.rx_valid = 1'b1;
            u_if.rx_data  = 8'h0D;
            @(posedge clk); #1;
        end
        u_if.rx_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // uart transmitter model: busy for 6 cycles after each send
    initial begin
        u_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.tx_send) begin
                tx_q.push_back(u_if.tx_data);
                if (busy_cnt > 0 || hold_busy) viol++;
                busy_cnt = 6;
            end else if (busy_cnt > 0) busy_cnt--;
            if (cmd_err) err_cnt++;
            u_if.tx_busy = hold_busy || (busy_cnt > 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n         = 1'b0;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_send", 32'(u_if.tx_send), 32'h0);
        chk("rst_data", 32'(u_if.tx_data), 32'h0);
        chk("rst_err", 32'(cmd_err), 32'h0);
        rst_n = 1'b1;
        drain(2);

        send("T2", 1);
        chk("t2_led", 32'(led_out), 32'h4);
        chk("t2_nosend_n1", 32'(u_if.tx_send), 32'h0);
        drain(1);
        chk("t2_send_n2", 32'(u_if.tx_send), 32'h1);
        chk("t2_data_n2", 32'(u_if.tx_data), 32'h4B);
        drain(20);
        chk_tx("t2", 1, 32'h4B);

        send("WA5", 1);
        chk("wa5_led", 32'(led_out), 32'h5);
        send("R", 1);
        drain(60);
        chk_tx("wr_rd", 4, 32'h4B30354B);

        err_cnt = 0;
        send("T7", 1);
        drain(15);
        send("Q", 1);
        drain(15);
        send("W1", 1);
        drain(20);
        chk("bad_errs", 32'(err_cnt), 32'd3);
        chk("bad_led", 32'(led_out), 32'h5);
        chk_tx("bad", 3, 32'h454545);

        err_cnt = 0;
        send("W3", 0);
        lat = 0;
        for (int k = 1; k <= 4 * TMO; k++) begin
            @(posedge clk); #1;
            if (cmd_err) begin
                lat = k;
                break;
            end
        end
        chk("tmo_lat", 32'(lat), 32'(TMO));
        drain(15);
        chk("tmo_errs", 32'(err_cnt), 32'd1);
        chk_tx("tmo", 1, 32'h45);
        send("T0", 1);
        chk("tmo_t0_led", 32'(led_out), 32'h4);
        drain(30);
        chk_tx("tmo_t0", 1, 32'h4B);

        err_cnt   = 0;
        hold_busy = 1'b1;
        drain(1);
        send("R", 1);
        send("T0", 1);
        send("T1", 1);
        drain(10);
        chk("full_led", 32'(led_out), 32'h5);
        chk("full_errs", 32'(err_cnt), 32'd1);
        chk("full_held", 32'(tx_q.size()), 32'd0);
        hold_busy = 1'b0;
        drain(60);
        chk_tx("full", 4, 32'h30344B4B);

        hold_busy = 1'b1;
        drain(1);
        send("T1", 1);
        send("T0", 1);
        chk("pre_rst_led", 32'(led_out), 32'h6);
        send("W", 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led", 32'(led_out), 32'h0);
        chk("mid_rst_data", 32'(u_if.tx_data), 32'h0);
        drain(2);
        chk("mid_rst_send", 32'(u_if.tx_send), 32'h0);
        rst_n     = 1'b1;
        hold_busy = 1'b0;
        tx_q.delete();
        drain(30);
        chk("post_rst_notx", 32'(tx_q.size()), 32'd0);
        send("R", 1);
        drain(40);
        chk_tx("post_rst_rd", 3, 32'h30304B);
        chk("post_rst_led", 32'(led_out), 32'h0);
        chk("busy_viol", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the uart receiver and upstream of its transmitter.
- Consumes the uart rx byte stream (valid/rx_data) and parses ASCII LED commands into an LED register.
- Queues ASCII acknowledgement bytes and feeds them back to the uart transmit side (send/tx_data) under a busy handshake.
- Replaces the ad-hoc single-byte LED toggle logic in the top level; one instance per uart channel.

Parameters:
- LED_WIDTH, 4, number of LED register bits, range 1..8.
- TIMEOUT_CYCLES, 4000000, idle clocks inside a partial command before it is abandoned (100 ms at 40 MHz).
- RESP_DEPTH, 4, response FIFO depth in bytes, power of two, at least 4.

Ports:
- clk  in  1  system clock (PLL 40 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe from uart; rx_data is valid in that cycle.
- rx_data  in  8  received byte.
- tx_busy  in  1  uart transmitter busy; high while a byte is shifting out.
- tx_send  out  1  one-cycle strobe to uart to start transmitting tx_data.
- tx_data  out  8  byte to transmit; valid in the tx_send cycle.
- led_out  out  LED_WIDTH  LED register.
- cmd_err  out  1  one-cycle pulse on any rejected or dropped command.

Behaviour:
- Reset: state IDLE, led_out 0, tx_send 0, tx_data 0x00, cmd_err 0, FIFO empty, timeout counter 0.
- Command set (uppercase letters; hex digits 0-9, A-F, a-f; terminator CR 0x0D):
  - "T d CR": toggle led_out[d]. d is ASCII '0'..LED_WIDTH-1; any other d is an error.
  - "W h h CR": led_out <= the hex byte, truncated to LED_WIDTH bits.
  - "R CR": respond with two uppercase hex chars of the zero-extended led_out, then "K".
- Responses: success on T or W queues "K" (0x4B); any error queues "E" (0x45).
- LF (0x0A) is ignored in every state. CR in IDLE is ignored (empty line).
- FSM states: IDLE, ARG1, ARG2, WAIT_CR, DISCARD.
  - IDLE: 'T' goes to ARG1(toggle); 'W' goes to ARG1(write); 'R' goes to WAIT_CR(read); any other byte goes to DISCARD.
  - ARG1: valid digit latched. Toggle goes to WAIT_CR; write goes to ARG2.
  - ARG2: valid hex digit goes to WAIT_CR.
  - WAIT_CR: CR executes the command and goes to IDLE.
  - Invalid byte in ARG1, ARG2 or WAIT_CR goes to DISCARD.
  - CR in ARG1 or ARG2 queues "E", pulses cmd_err, goes to IDLE.
  - DISCARD: stays until CR, then queues "E", pulses cmd_err, goes to IDLE.
- Timeout:
  - The counter clears on every rx_valid and while in IDLE.
  - When it reaches TIMEOUT_CYCLES-1 in any non-IDLE state: queue "E", pulse cmd_err, go to IDLE.
  - If rx_valid and expiry occur in the same cycle, the byte wins: it is processed and the counter clears.
- Execution timing: for a CR strobe in cycle N, led_out updates and response bytes are written at the N+1 edge. All bytes of one response are written in the same cycle.
- FIFO space check: a command executes only if the FIFO has free slots for its whole response (1 byte, or 3 for R). Otherwise led_out is unchanged, nothing is queued, cmd_err pulses, and the FSM returns to IDLE. An error response with no free slot is dropped and cmd_err still pulses.
- Back-to-back rx_valid on consecutive cycles is supported; no byte is lost.
- Transmit side:
  - When the FIFO is non-empty, tx_busy is 0 and no holdoff is active: assert tx_send for one cycle with tx_data = head, and pop.
  - A 2-cycle holdoff follows every tx_send, during which tx_busy is ignored; this covers the uart's busy-rise latency.
  - Earliest tx_send is cycle N+2 after the CR strobe.
  - FIFO push and pop in the same cycle are both honoured.
- Reset asserted mid-command or mid-response: all state returns to reset values immediately, the FIFO is flushed, and no partial tx_send is issued.

Test Plan:
- Send "T2\r" with led_out=0 -> led_out=0x4 one cycle after CR; one tx_send with tx_data 0x4B.
- Send "WA5\r" with LED_WIDTH=4, then "R\r" -> led_out=0x5; tx sequence 0x4B, 0x30, 0x35, 0x4B; each tx_send waits for tx_busy low plus holdoff.
- Send "T7\r", "Q\r" and "W1\r" -> each gives cmd_err pulse and tx 0x45; led_out unchanged.
- Send "W3" then silence for TIMEOUT_CYCLES -> "E" queued and cmd_err; a following "T0\r" is accepted (led_out bit0 toggles, "K").
- Hold tx_busy=1 and send "R\r", "T0\r", "T1\r" -> FIFO holds 4 bytes; "T1" is rejected with cmd_err and led_out bit1 unchanged. Release tx_busy -> exactly 4 bytes drain.
- Assert rst_n=0 between 'W' and the first hex digit, with 2 bytes queued -> led_out=0, FIFO empty, no tx_send; "R\r" after release returns "00K".
